// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader and its UART receiver.
package prog_loader_pkg;

   typedef enum logic [1:0] {
      LDR_WAIT_SYNC = 2'd0,
      LDR_LOAD      = 2'd1,
      LDR_ERROR     = 2'd2
   } ldr_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam logic [7:0] LDR_SYNC_BYTE  = 8'hA5;
   localparam int         RX_SYNC_STAGES = 2;

   // UART sends LSB first, so each new bit enters at the top and moves down.
   function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] cur, input logic bit_in);
      return {bit_in, cur[7:1]};
   endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: synchroniser, start validation, mid-bit sampling, one-cycle
// rx_valid or rx_ferr pulse per frame.
module uart_rx
   import prog_loader_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int                CNT_W   = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);

   // Synchroniser resets to the idle-high level so reset release never looks like a start edge.
   logic [RX_SYNC_STAGES-1:0] sync_reg;
   logic                      rxd_prev_reg;
   logic                      rxd_s;
   logic                      rx_fall;

   rx_state_t        rx_state_reg, rx_state_next;
   logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [7:0]       shift_reg, shift_next;
   logic             rx_valid_reg, rx_valid_next;
   logic             rx_ferr_reg, rx_ferr_next;

   assign rxd_s   = sync_reg[RX_SYNC_STAGES-1];
   assign rx_fall = rxd_prev_reg & ~rxd_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg     <= '1;
         rxd_prev_reg <= 1'b1;
      end else begin
         sync_reg     <= {sync_reg[RX_SYNC_STAGES-2:0], rxd};
         rxd_prev_reg <= rxd_s;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_reg <= RX_IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         rx_valid_reg <= 1'b0;
         rx_ferr_reg  <= 1'b0;
      end else begin
         rx_state_reg <= rx_state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         rx_valid_reg <= rx_valid_next;
         rx_ferr_reg  <= rx_ferr_next;
      end
   end

   always_comb begin
      rx_state_next = rx_state_reg;
      baud_cnt_next = baud_cnt_reg + CNT_W'(1);
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      rx_valid_next = 1'b0;
      rx_ferr_next  = 1'b0;

      case (rx_state_reg)
         RX_IDLE: begin
            // Needs a genuine 1->0 edge, so a held-low break cannot re-arm by itself.
            baud_cnt_next = '0;
            if (rx_fall) begin
               rx_state_next = RX_START;
            end
         end
         RX_START: begin
            if (baud_cnt_reg == HALF_M1) begin
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
               rx_state_next = rxd_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (baud_cnt_reg == FULL_M1) begin
               baud_cnt_next = '0;
               shift_next    = shift_in_lsb_first(shift_reg, rxd_s);
               bit_cnt_next  = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  rx_state_next = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (baud_cnt_reg == FULL_M1) begin
               baud_cnt_next = '0;
               rx_state_next = RX_IDLE;
               rx_valid_next = rxd_s;
               rx_ferr_next  = ~rxd_s;
            end
         end
         default: begin
            rx_state_next = RX_IDLE;
         end
      endcase
   end

   assign rx_data  = shift_reg;
   assign rx_valid = rx_valid_reg;
   assign rx_ferr  = rx_ferr_reg;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: a sync byte opens a load of 2**ADRS_W bytes into program
// memory while the CPU is held in reset.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int         CLK_DIV   = 434,
   parameter int         ADRS_W    = 4,
   parameter logic [7:0] SYNC_BYTE = LDR_SYNC_BYTE
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rxd,
   output logic              mem_we,
   output logic [ADRS_W-1:0] mem_adrs,
   output logic [7:0]        mem_dat,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [ADRS_W-1:0] LAST_ADRS = {ADRS_W{1'b1}};

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;
   logic       sync_seen;

   uart_rx #(
      .CLK_DIV (CLK_DIV)
   ) u_uart_rx (
      .clk      (clk),
      .reset_n  (reset_n),
      .rxd      (rxd),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   ldr_state_t        state_reg, state_next;
   logic [ADRS_W-1:0] adrs_reg, adrs_next;
   logic              mem_we_reg, mem_we_next;
   logic [ADRS_W-1:0] mem_adrs_reg, mem_adrs_next;
   logic [7:0]        mem_dat_reg, mem_dat_next;
   logic              cpu_hold_reg, cpu_hold_next;
   logic              load_done_reg, load_done_next;
   logic              load_err_reg, load_err_next;

   assign sync_seen = rx_valid && (rx_data == SYNC_BYTE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= LDR_WAIT_SYNC;
         adrs_reg      <= '0;
         mem_we_reg    <= 1'b0;
         mem_adrs_reg  <= '0;
         mem_dat_reg   <= '0;
         cpu_hold_reg  <= 1'b0;
         load_done_reg <= 1'b0;
         load_err_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         adrs_reg      <= adrs_next;
         mem_we_reg    <= mem_we_next;
         mem_adrs_reg  <= mem_adrs_next;
         mem_dat_reg   <= mem_dat_next;
         cpu_hold_reg  <= cpu_hold_next;
         load_done_reg <= load_done_next;
         load_err_reg  <= load_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      adrs_next      = adrs_reg;
      mem_we_next    = 1'b0;
      mem_adrs_next  = mem_adrs_reg;
      mem_dat_next   = mem_dat_reg;
      load_done_next = 1'b0;
      load_err_next  = load_err_reg;

      case (state_reg)
         LDR_WAIT_SYNC: begin
            if (sync_seen) begin
               state_next    = LDR_LOAD;
               adrs_next     = '0;
               load_err_next = 1'b0;
            end
         end
         LDR_LOAD: begin
            if (rx_valid) begin
               mem_we_next   = 1'b1;
               mem_adrs_next = adrs_reg;
               mem_dat_next  = rx_data;
               adrs_next     = adrs_reg + ADRS_W'(1);
               if (adrs_reg == LAST_ADRS) begin
                  load_done_next = 1'b1;
                  state_next     = LDR_WAIT_SYNC;
               end
            end else if (rx_ferr) begin
               state_next    = LDR_ERROR;
               load_err_next = 1'b1;
            end
         end
         LDR_ERROR: begin
            if (sync_seen) begin
               state_next    = LDR_LOAD;
               adrs_next     = '0;
               load_err_next = 1'b0;
            end
         end
         default: begin
            state_next = LDR_WAIT_SYNC;
         end
      endcase

      // Hold stays up through the final write so the CPU never runs on a half-written image.
      cpu_hold_next = (state_next != LDR_WAIT_SYNC) || load_done_next;
   end

   assign mem_we    = mem_we_reg;
   assign mem_adrs  = mem_adrs_reg;
   assign mem_dat   = mem_dat_reg;
   assign cpu_hold  = cpu_hold_reg;
   assign load_done = load_done_reg;
   assign load_err  = load_err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of UART bytes with expected write/flag outcome,
// plus hand sequences for reset, false start and mid-load reset.
module tb_prog_loader;

   localparam int CLK_DIV = 8;
   localparam int ADRS_W  = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              rxd = 1'b1;
   logic              mem_we;
   logic [ADRS_W-1:0] mem_adrs;
   logic [7:0]        mem_dat;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;

   always #5 clk = ~clk;

   prog_loader #(
      .CLK_DIV   (CLK_DIV),
      .ADRS_W    (ADRS_W),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rxd       (rxd),
      .mem_we    (mem_we),
      .mem_adrs  (mem_adrs),
      .mem_dat   (mem_dat),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   typedef struct {
      logic [7:0]        data;
      logic              stop;
      logic              exp_we;
      logic [ADRS_W-1:0] exp_adrs;
      logic              exp_done;
      logic              exp_hold;
      logic              exp_err;
   } vec_t;

   typedef struct {
      logic [ADRS_W-1:0] adrs;
      logic [7:0]        dat;
      logic              done;
      logic              hold;
   } wr_t;

   vec_t vecs[$];
   wr_t  wr_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   stray_done = 0;
   int   long_we = 0;
   logic we_prev = 1'b0;

   always @(negedge clk) begin
      if (mem_we) wr_q.push_back('{mem_adrs, mem_dat, load_done, cpu_hold});
      else if (load_done) stray_done <= stray_done + 1;
      if (mem_we && we_prev) long_we <= long_we + 1;
      we_prev <= mem_we;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      rxd = 1'b0;
      tick(CLK_DIV);
      for (int b = 0; b < 8; b++) begin
         rxd = d[b];
         tick(CLK_DIV);
      end
      rxd = stop;
      tick(CLK_DIV);
      rxd = 1'b1;
      tick(2 * CLK_DIV);
   endtask

   function automatic void add(input logic [7:0] d, input logic stop, input logic we,
                               input logic [ADRS_W-1:0] adrs, input logic done,
                               input logic hold, input logic err);
      vecs.push_back('{d, stop, we, adrs, done, hold, err});
   endfunction

   initial begin
      // load of 00..0F
      add(8'hA5, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++)
         add(8'(i), 1, 1, 4'(i), (i == 15), (i != 15), 0);
      // ignored while waiting for sync
      add(8'h3C, 1, 0, 0, 0, 0, 0);
      add(8'h5A, 1, 0, 0, 0, 0, 0);
      // framing error after four writes
      add(8'hA5, 1, 0, 0, 0, 1, 0);
      add(8'h11, 1, 1, 0, 0, 1, 0);
      add(8'h22, 1, 1, 1, 0, 1, 0);
      add(8'h33, 1, 1, 2, 0, 1, 0);
      add(8'h44, 1, 1, 3, 0, 1, 0);
      add(8'h55, 0, 0, 0, 0, 1, 1);
      // sync clears the error; a second A5 is plain data at address 0
      add(8'hA5, 1, 0, 0, 0, 1, 0);
      add(8'hA5, 1, 1, 0, 0, 1, 0);
      for (int i = 1; i < 7; i++)
         add(8'(8'h10 * i + i), 1, 1, 4'(i), 0, 1, 0);

      // reset state, checked while reset is still asserted
      tick(4);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_adrs", mem_adrs, 0);
      check("rst_mem_dat", mem_dat, 0);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_load_done", load_done, 0);
      check("rst_load_err", load_err, 0);
      reset_n = 1'b1;
      tick(3 * CLK_DIV);

      foreach (vecs[i]) begin
         wr_q.delete();
         send_byte(vecs[i].data, vecs[i].stop);
         check($sformatf("v%0d_nwrites", i), wr_q.size(), 32'(vecs[i].exp_we));
         if (wr_q.size() == 1 && vecs[i].exp_we) begin
            check($sformatf("v%0d_adrs", i), wr_q[0].adrs, vecs[i].exp_adrs);
            check($sformatf("v%0d_dat", i), wr_q[0].dat, vecs[i].data);
            check($sformatf("v%0d_done", i), wr_q[0].done, vecs[i].exp_done);
            check($sformatf("v%0d_hold_at_we", i), wr_q[0].hold, 1);
         end
         check($sformatf("v%0d_cpu_hold", i), cpu_hold, vecs[i].exp_hold);
         check($sformatf("v%0d_load_err", i), load_err, vecs[i].exp_err);
         $display("byte %0d: data=%02h stop=%0b writes=%0d hold=%0b err=%0b",
                  i, vecs[i].data, vecs[i].stop, wr_q.size(), cpu_hold, load_err);
      end

      // 3-clock low glitch mid-load must not produce a byte
      wr_q.delete();
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(25 * CLK_DIV);
      check("glitch_nwrites", wr_q.size(), 0);
      check("glitch_cpu_hold", cpu_hold, 1);
      check("glitch_load_err", load_err, 0);
      $display("false start: writes=%0d hold=%0b", wr_q.size(), cpu_hold);

      // asynchronous reset mid-load, asserted away from the clock edge
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("midrst_cpu_hold", cpu_hold, 0);
      check("midrst_mem_we", mem_we, 0);
      check("midrst_mem_adrs", mem_adrs, 0);
      check("midrst_mem_dat", mem_dat, 0);
      $display("mid-load reset: hold=%0b adrs=%0h dat=%02h", cpu_hold, mem_adrs, mem_dat);
      tick(3);
      reset_n = 1'b1;
      tick(2 * CLK_DIV);

      wr_q.delete();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h3E, 1'b1);
      check("reload_nwrites", wr_q.size(), 1);
      if (wr_q.size() == 1) begin
         check("reload_adrs", wr_q[0].adrs, 0);
         check("reload_dat", wr_q[0].dat, 8'h3E);
      end
      check("reload_cpu_hold", cpu_hold, 1);
      $display("reload after reset: writes=%0d hold=%0b", wr_q.size(), cpu_hold);

      check("stray_load_done", stray_done, 0);
      check("mem_we_width", long_we, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
